// File: rtl/rt_pkg.sv
// Shared ray-tracer output types: pixel word width, coordinate width and
// the AXI-Stream packer FIFO entry layout.
package rt_pkg;

  localparam int FP_WL           = 24;
  localparam int COORDINATE_BITS = 12;

  typedef struct packed {
    logic [FP_WL-1:0] pixel;
    logic             sof;
    logic             eol;
    logic             eof;
  } rt_axis_entry_t;

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } frame_state_t;

endpackage

// File: rtl/rt_sync_fifo.sv
// Synchronous FIFO with a registered head word: dout always shows the oldest
// entry and holds its last value once the FIFO drains.
module rt_sync_fifo #(
  parameter int  DEPTH   = 8,
  parameter type entry_t = logic [7:0]
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  entry_t                     din,
  output entry_t                     dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [CW-1:0] count_next;
  logic          wr_en;
  logic          rd_en;
  logic          write_is_head;

  assign full          = (count == CW'(DEPTH));
  assign empty         = (count == '0);
  assign rd_en         = pop & ~empty;
  assign wr_en         = push & (~full | rd_en);
  assign rd_next       = rd_ptr + AW'(rd_en);
  assign count_next    = count + CW'(wr_en) - CW'(rd_en);
  // The incoming word becomes the head only when nothing older survives this cycle.
  assign write_is_head = wr_en & ((count - CW'(rd_en)) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_next;
      count  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= '0;
    end else if (count_next != '0) begin
      dout <= write_is_head ? din : mem[rd_next];
    end
  end

endmodule

// File: rtl/rt_axis_packer.sv
// Ray-tracer core to AXI4-Stream video packer with stall backpressure.
// Define RT_AXIS_TLAST_LINE_EN for per-line tlast; otherwise tlast marks end of frame.
module rt_axis_packer
  import rt_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int STALL_SLACK = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic [FP_WL-1:0]           in_pixel,
  output logic                       in_stall,
  input  logic [COORDINATE_BITS-1:0] image_width,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [FP_WL-1:0]           m_axis_tdata,
  output logic                       m_axis_tuser,
  output logic                       m_axis_tlast,
  output logic                       frame_done,
  output logic                       overflow,
  output logic                       line_err
);

  localparam int             CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]  STALL_THR = CW'(FIFO_DEPTH - STALL_SLACK);

  rt_axis_entry_t push_entry;
  rt_axis_entry_t head;
  frame_state_t   state;
  frame_state_t   state_next;
  logic           full;
  logic           empty;
  logic           pop;
  logic           push_ok;
  logic           sof;
  logic           eol;
  logic [CW-1:0]  occ;
  logic [CW-1:0]  occ_next;

  assign pop      = ~empty & m_axis_tready;
  assign push_ok  = in_valid & (~full | pop);
  assign occ_next = occ + CW'(push_ok) - CW'(pop);

  always_comb begin
    state_next = state;
    sof        = 1'b0;
    case (state)
      S_IDLE: begin
        sof = 1'b1;
        if (push_ok && !in_last) state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (push_ok && in_last) state_next = S_IDLE;
      end
    endcase
  end

`ifdef RT_AXIS_TLAST_LINE_EN
  logic [COORDINATE_BITS-1:0] col;
  logic [COORDINATE_BITS-1:0] width_q;
  logic [COORDINATE_BITS-1:0] cur_width;
  logic [COORDINATE_BITS-1:0] last_col;
  logic                       at_end;

  // A zero width wraps last_col to all ones, i.e. a 2^COORDINATE_BITS line.
  assign cur_width = sof ? image_width : width_q;
  assign last_col  = cur_width - COORDINATE_BITS'(1);
  assign at_end    = (col == last_col);
  assign eol       = at_end | in_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col      <= '0;
      line_err <= 1'b0;
    end else if (push_ok) begin
      col <= eol ? '0 : col + COORDINATE_BITS'(1);
      if (in_last && !at_end) line_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && sof) width_q <= image_width;
  end
`else
  logic unused_image_width;

  assign eol                = in_last;
  assign line_err           = 1'b0;
  assign unused_image_width = ^image_width;
`endif

  always_comb begin
    push_entry.pixel = in_pixel;
    push_entry.sof   = sof;
    push_entry.eol   = eol;
    push_entry.eof   = in_last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      in_stall <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      in_stall <= (occ_next >= STALL_THR);
      if (in_valid && !push_ok) overflow <= 1'b1;
    end
  end

  rt_sync_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (rt_axis_entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  assign m_axis_tvalid = ~empty;
  assign m_axis_tdata  = head.pixel;
  assign m_axis_tuser  = head.sof;
  assign m_axis_tlast  = head.eol;
  assign frame_done    = pop & head.eof;

endmodule

// File: tb/tb_rt_axis_packer.sv
// Scoreboard bench for rt_axis_packer: a queue-level reference model predicts
// every output word, occupancy-derived stall and the sticky error flags.
module tb_rt_axis_packer;
  import rt_pkg::*;

  localparam int DEPTH = 8;
  localparam int SLACK = 4;
  localparam int THR   = DEPTH - SLACK;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       in_valid = 1'b0;
  logic                       in_last = 1'b0;
  logic [FP_WL-1:0]           in_pixel = '0;
  logic                       in_stall;
  logic [COORDINATE_BITS-1:0] image_width = 12'd4;
  logic                       m_axis_tvalid;
  logic                       m_axis_tready = 1'b0;
  logic [FP_WL-1:0]           m_axis_tdata;
  logic                       m_axis_tuser;
  logic                       m_axis_tlast;
  logic                       frame_done;
  logic                       overflow;
  logic                       line_err;

  always #5 clk = ~clk;

  rt_axis_packer #(.FIFO_DEPTH(DEPTH), .STALL_SLACK(SLACK)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_pixel      (in_pixel),
    .in_stall      (in_stall),
    .image_width   (image_width),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .frame_done    (frame_done),
    .overflow      (overflow),
    .line_err      (line_err)
  );

  typedef struct {
    logic [FP_WL-1:0] pixel;
    bit               sof;
    bit               eol;
    bit               eof;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: queue occupancy, frame/line position, sticky flags.
  int m_occ      = 0;
  bit m_in_frame = 0;
  int m_width    = 0;
  int m_col      = 0;
  bit m_ovf      = 0;
  bit m_lerr     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        exp_q.delete();
        m_occ = 0; m_in_frame = 0; m_col = 0; m_ovf = 0; m_lerr = 0;
      end else begin
        bit   pop, acc;
        exp_t e;
        pop = (m_occ > 0) && m_axis_tready;
        acc = in_valid && ((m_occ < DEPTH) || pop);
        if (in_valid && !acc) m_ovf = 1;
        if (acc) begin
          e.pixel = in_pixel;
          e.sof   = !m_in_frame;
          e.eof   = in_last;
`ifdef RT_AXIS_TLAST_LINE_EN
          if (e.sof) m_width = (image_width == 0) ? (1 << COORDINATE_BITS) : int'(image_width);
          e.eol = (m_col == m_width - 1) || in_last;
          if (in_last && m_col != m_width - 1) m_lerr = 1;
          m_col = e.eol ? 0 : m_col + 1;
`else
          e.eol = in_last;
`endif
          m_in_frame = !in_last;
          exp_q.push_back(e);
        end
        m_occ = m_occ + int'(acc) - int'(pop);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_in_stall", in_stall, 0);
        chk("rst_overflow", overflow, 0);
      end else begin
        chk("tvalid", m_axis_tvalid, m_occ > 0);
        chk("in_stall", in_stall, m_occ >= THR);
        chk("overflow", overflow, m_ovf);
        chk("line_err", line_err, m_lerr);
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("tdata", m_axis_tdata, e.pixel);
            chk("tuser", m_axis_tuser, e.sof);
            chk("tlast", m_axis_tlast, e.eol);
            chk("frame_done", frame_done, e.eof);
          end
        end else begin
          chk("frame_done_idle", frame_done, 0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit l, input bit rdy);
    in_valid      = v;
    in_last       = l;
    m_axis_tready = rdy;
    in_pixel      = FP_WL'($urandom);
    step();
  endtask

  task automatic do_reset();
    in_valid = 0; in_last = 0;
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic drain(input int budget);
    int n;
    in_valid = 0; in_last = 0; m_axis_tready = 1;
    n = 0;
    while (m_occ > 0 && n < budget) begin
      step();
      n++;
    end
    step();
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_tvalid", m_axis_tvalid, 0);
  endtask

  initial begin
    bit [3:0] hist;
    bit       seen_stall;
    int       sent;

    step(); step(); step();
    chk("reset_tvalid", m_axis_tvalid, 0);
    chk("reset_tdata", m_axis_tdata, 0);
    chk("reset_tuser", m_axis_tuser, 0);
    chk("reset_tlast", m_axis_tlast, 0);
    chk("reset_stall", in_stall, 0);
    chk("reset_line_err", line_err, 0);
    reset = 0;
    step();

    // Scenario 1: width 4, one 8-pixel frame at full rate.
    image_width = 12'd4;
    for (int i = 0; i < 8; i++) drive(1, i == 7, 1);
    drain(20);
    chk("s1_line_err", line_err, 0);

    // Scenario 2: ready low for 20 cycles, core honours stall with 4 cycles latency.
    hist = '0; seen_stall = 0; sent = 0;
    for (int c = 0; c < 80 && sent < 16; c++) begin
      bit v;
      v = !hist[3];
      drive(v, v && sent == 15, c >= 20);
      if (v) sent++;
      hist = {hist[2:0], in_stall};
      if (in_stall) seen_stall = 1;
    end
    drain(30);
    chk("s2_stall_seen", seen_stall, 1);
    chk("s2_overflow", overflow, 0);

    // Scenario 3: overflow on full FIFO, accept when popping at the same time.
    do_reset();
    for (int i = 0; i < 8; i++) drive(1, 0, 0);
    drive(1, 0, 0);
    chk("s3_overflow_set", overflow, 1);
    drive(1, 0, 1);
    chk("s3_still_full", m_axis_tvalid, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0);
    chk("s3_overflow_sticky", overflow, 1);
    drive(1, 1, 1);
    drain(20);
    do_reset();
    chk("s3_overflow_cleared", overflow, 0);

    // Scenario 4: in_last on the 6th pixel of a width-4 frame.
    image_width = 12'd4;
    for (int i = 0; i < 6; i++) drive(1, i == 5, 1);
    drain(20);
`ifdef RT_AXIS_TLAST_LINE_EN
    chk("s4_line_err", line_err, 1);
`else
    chk("s4_line_err", line_err, 0);
`endif

    // Scenario 5: reset mid-frame with 3 entries queued.
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 0, 0);
    in_valid = 0;
    reset = 1;
    #1;
    chk("s5_tvalid_at_reset", m_axis_tvalid, 0);
    step();
    reset = 0;
    drive(1, 0, 0);
    chk("s5_tvalid", m_axis_tvalid, 1);
    chk("s5_tuser", m_axis_tuser, 1);
    drive(1, 1, 1);
    drain(20);

    // Random traffic, stall not honoured so drops occur too.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int widths[6];
      widths = '{1, 2, 3, 4, 5, 7};
      image_width = COORDINATE_BITS'(widths[$urandom_range(0, 5)]);
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 11) == 0, $urandom_range(0, 9) < 7);
    end
    drain(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
